// File: rtl/mc_control.sv
// Multi-cycle MIPS-style main control unit: Moore FSM producing datapath
// strobes, with a bounded memory-wait timeout and a retired-instruction counter.
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_J     = 6'd2;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               mem_wait_st;
  logic               wait_last;
  logic               abort;
  logic               retire;

  // funct_i is decoded downstream by ALU control, never here.
  logic unused_funct;
  assign unused_funct = ^funct_i;

  assign mem_wait_st = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_last   = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    abort     = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      S_IF: begin
        if (mem_ready_i)    state_d = S_ID;
        else if (wait_last) abort   = 1'b1;
      end
      S_ID: begin
        unique case (op_i)
          OP_RTYPE:      state_d = S_EXE_R;
          OP_ADDI:       state_d = S_EXE_I;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:          state_d = S_JMP;
          default: begin
            state_d   = S_IF;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXE_R: state_d = S_WB_R;
      S_EXE_I: state_d = S_WB_I;
      S_ADDR: begin
        if (op_i == OP_LW)      state_d = S_MEM_RD;
        else if (op_i == OP_SW) state_d = S_MEM_WR;
        else                    state_d = S_IF;
      end
      S_MEM_RD: begin
        if (mem_ready_i)    state_d = S_WB_MEM;
        else if (wait_last) abort   = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready_i) begin
          state_d = S_IF;
          retire  = 1'b1;
        end else if (wait_last) begin
          abort = 1'b1;
        end
      end
      S_WB_MEM, S_WB_R, S_WB_I, S_BR, S_JMP: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    if (abort) begin
      state_d   = S_IF;
      illegal_d = 1'b1;
    end

    // Counter is zero outside the wait states, so entering any of them starts fresh.
    wait_d    = (mem_wait_st && !mem_ready_i && !abort) ? wait_q + WAIT_W'(1) : '0;
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 2'd0;
    pc_source_o  = 2'd0;
    unique case (state_q)
      S_IF: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'd1;
        // Fetch writes are suppressed while reset is held low.
        ir_write_o  = mem_ready_i && rst_i;
        pc_write_o  = mem_ready_i && rst_i;
      end
      S_ID:    alu_src_b_o = 2'd3;
      S_EXE_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'd2;
      end
      S_EXE_I, S_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
      end
      S_MEM_RD: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
      end
      S_MEM_WR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_WB_I:  reg_write_o = 1'b1;
      S_BR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'd1;
        pc_source_o = 2'd1;
        pc_write_o  = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);
      end
      S_JMP: begin
        pc_source_o = 2'd2;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign retired_o = retired_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles waiting for mem_ready_i per access before abort.
REQ-002 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low; rst_i=0 forces reset state immediately.
REQ-005 op_i  input  6  opcode field of instruction register.
REQ-006 funct_i  input  6  funct field of instruction register.
REQ-007 zero_i  input  1  ALU zero flag.
REQ-008 mem_ready_i  input  1  memory completes current access this cycle.
REQ-009 pc_write_o  output  1  load PC this edge.
REQ-010 ir_write_o  output  1  load instruction register this edge.
REQ-011 iord_o  output  1  memory address select: 0=PC, 1=ALU result register.
REQ-012 mem_read_o / mem_write_o  output  1 each  memory strobes.
REQ-013 reg_write_o  output  1; reg_dst_o  output  1 (0=rt, 1=rd); mem_to_reg_o  output  1.
REQ-014 alu_src_a_o  output  1 (0=PC, 1=rs); alu_src_b_o  output  2 (0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2).
REQ-015 alu_op_o  output  2 (0=add, 1=sub, 2=funct-decoded); pc_source_o  output  2 (0=ALU, 1=ALUOut, 2=jump target).
REQ-016 state_o  output  4  current state code; illegal_o  output  1  one-cycle pulse on bad opcode or memory timeout.
REQ-017 retired_o  output  CNT_W  count of completed instructions.

Function
REQ-018 Moore FSM, codes: IF=0, ID=1, EXE_R=2, EXE_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_R=8, WB_I=9, BR=10, JMP=11.
REQ-019 IF: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=0, pc_source_o=0; ir_write_o and pc_write_o = mem_ready_i; stay until mem_ready_i=1, then ID.
REQ-020 ID: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=0 (branch target precompute); next by op_i: 0->EXE_R, 8->EXE_I, 35/43->ADDR, 4/5->BR, 2->JMP, other->IF with illegal_o=1.
REQ-021 EXE_R: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=2 -> WB_R; WB_R: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0 -> IF.
REQ-022 EXE_I: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=0 -> WB_I; WB_I: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0 -> IF.
REQ-023 ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=0 -> MEM_RD if op_i=35, MEM_WR if op_i=43.
REQ-024 MEM_RD/MEM_WR: iord_o=1, strobe held until mem_ready_i=1; MEM_RD -> WB_MEM, MEM_WR -> IF.
REQ-025 WB_MEM: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1 -> IF.
REQ-026 BR: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=1, pc_source_o=1; pc_write_o = zero_i for op 4, ~zero_i for op 5; -> IF.
REQ-027 JMP: pc_source_o=2, pc_write_o=1 -> IF.
REQ-028 All outputs not listed for a state SHALL be 0; funct_i is not decoded here (passed via alu_op_o=2 to ALU control).
REQ-029 Wait counter clears on entering IF/MEM_RD/MEM_WR, increments each cycle mem_ready_i=0; reaching MEM_TIMEOUT -> IF, illegal_o=1 for one cycle, strobes deasserted, pc_write_o=0.
REQ-030 retired_o increments by 1 on leaving WB_R, WB_I, WB_MEM, MEM_WR (with ready), BR, JMP; wraps modulo 2^CNT_W; not incremented on illegal/timeout.
REQ-031 mem_ready_i in states other than IF/MEM_RD/MEM_WR SHALL be ignored.

Reset
REQ-032 rst_i=0: state=IF, wait counter=0, retired_o=0, illegal_o=0; asserting mid-instruction (incl. mid memory wait) aborts with no further pc/reg/mem writes.
REQ-033 After rst_i rises, first edge evaluates IF with mem_read_o=1.

Verification
REQ-034 R-type (op 0), mem_ready_i=1 in IF -> states 0,1,2,8,0; reg_write_o=1 only in state 8; retired_o 0->1.
REQ-035 lw (op 35), mem_ready_i low 3 cycles in MEM_RD -> mem_read_o,iord_o held 3+1 cycles, then WB_MEM with mem_to_reg_o=1.
REQ-036 beq with zero_i=1 -> pc_write_o=1, pc_source_o=1 in BR; bne with zero_i=1 -> pc_write_o=0.
REQ-037 op_i=63 in ID -> illegal_o pulse, next state IF, retired_o unchanged.
REQ-038 mem_ready_i stuck 0 in MEM_WR for 15 cycles -> illegal_o=1, state IF, mem_write_o=0.
REQ-039 rst_i=0 asserted during MEM_RD wait -> state_o=0, retired_o=0 immediately, no reg_write_o.
